// File: rtl/load_pkg.sv
// Shared definitions for the vector tile streamer.
//   state_t       : transfer FSM states
//   ceil_div      : integer ceiling division used for derived sizes
//   is_pow2       : power-of-two test
//   tile_geom_ok  : tile / bus geometry legality check used at elaboration
package load_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    HOLD,
    DONE
  } state_t;

  localparam int unsigned ELEM_BITS       = 8;
  localparam int unsigned MAX_MEM_LATENCY = 4;

  function automatic int unsigned ceil_div(input int unsigned num, input int unsigned den);
    return (num + den - 1) / den;
  endfunction

  function automatic bit is_pow2(input int unsigned v);
    return (v != 0) && ((v & (v - 1)) == 0);
  endfunction

  // Tile must hold a whole number of memory beats, and a beat must fit in a tile.
  function automatic bit tile_geom_ok(input int unsigned tile_w,
                                      input int unsigned data_w,
                                      input int unsigned mem_bytes);
    if (!is_pow2(mem_bytes)) return 1'b0;
    if ((tile_w % (data_w * mem_bytes)) != 0) return 1'b0;
    if (mem_bytes > (tile_w / data_w)) return 1'b0;
    return 1'b1;
  endfunction

endpackage

// File: rtl/load_beat_pipe.sv
// Read-latency tracker: a LATENCY-stage shift register carrying
// {valid, beat index, byte mask} for each issued memory beat, so the
// returning read data is captured into the right tile slot.
//   clk, rst   : clock, synchronous active-high clear of all stages
//   i_valid    : beat issued this cycle
//   i_idx      : beat index within the tile
//   i_mask     : per-byte keep mask (0 = force byte to zero)
//   o_*        : same fields, LATENCY cycles later
module load_beat_pipe #(
  parameter int unsigned LATENCY = 1,
  parameter int unsigned IDX_W   = 3,
  parameter int unsigned MASK_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_valid,
  input  logic [IDX_W-1:0]  i_idx,
  input  logic [MASK_W-1:0] i_mask,
  output logic              o_valid,
  output logic [IDX_W-1:0]  o_idx,
  output logic [MASK_W-1:0] o_mask
);

  localparam int unsigned SW = 1 + IDX_W + MASK_W;

  logic [SW-1:0] r_stage [LATENCY];

  for (genvar gs = 0; gs < LATENCY; gs++) begin : g_stage
    if (gs == 0) begin : g_head
      always_ff @(posedge clk) begin
        if (rst) r_stage[0] <= '0;
        else     r_stage[0] <= {i_valid, i_idx, i_mask};
      end
    end else begin : g_tail
      always_ff @(posedge clk) begin
        if (rst) r_stage[gs] <= '0;
        else     r_stage[gs] <= r_stage[gs-1];
      end
    end
  end

  assign {o_valid, o_idx, o_mask} = r_stage[LATENCY-1];

endmodule

// File: rtl/vec_tile_streamer.sv
// Vector loader: fetches `length` byte elements from DRAM over a
// MEM_BYTES-wide read port, packs them into TILE_WIDTH-bit tiles with the
// tail of the last tile zero-padded, and streams tiles on valid/ready.
//   clk, rst            : clock, synchronous active-high reset
//   valid_in            : start request, sampled only when idle
//   dram_addr, length   : start byte address (beat aligned), element count
//   mem_req, mem_addr   : one read beat per cycle
//   mem_rdata           : read data, MEM_LATENCY cycles after mem_req
//   data_out            : tile elements, element 0 first
//   tile_valid/ready    : tile handshake; tile_last marks the final tile
//   busy, done, err     : transfer status; err pulses with done on misalignment
module vec_tile_streamer
  import load_pkg::*;
#(
  parameter int unsigned TILE_WIDTH  = 256,
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned MEM_BYTES   = 4,
  parameter int unsigned MEM_LATENCY = 1,
  parameter int unsigned ADDR_WIDTH  = 24,
  parameter int unsigned LEN_WIDTH   = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   valid_in,
  input  logic [ADDR_WIDTH-1:0]  dram_addr,
  input  logic [LEN_WIDTH-1:0]   length,
  output logic                   mem_req,
  output logic [ADDR_WIDTH-1:0]  mem_addr,
  input  logic [MEM_BYTES*8-1:0] mem_rdata,
  output logic [7:0]             data_out [0:TILE_WIDTH/DATA_WIDTH-1],
  output logic                   tile_valid,
  input  logic                   tile_ready,
  output logic                   tile_last,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);

  localparam int unsigned ELEM_COUNT = TILE_WIDTH / DATA_WIDTH;
  localparam int unsigned BEATS      = ceil_div(ELEM_COUNT, MEM_BYTES);
  localparam int unsigned BIDX_W     = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned CNT_W      = $clog2(BEATS + 1) + 1;
  localparam int unsigned EW         = LEN_WIDTH + 1;
  localparam int unsigned XW         = LEN_WIDTH + 2;
  localparam bit          GEOM_OK    = tile_geom_ok(TILE_WIDTH, DATA_WIDTH, MEM_BYTES);

  if (DATA_WIDTH != ELEM_BITS) begin : g_bad_data_width
    $fatal(1, "vec_tile_streamer: DATA_WIDTH must be 8");
  end
  if (!GEOM_OK) begin : g_bad_geometry
    $fatal(1, "vec_tile_streamer: illegal TILE_WIDTH / MEM_BYTES combination");
  end
  if ((MEM_LATENCY < 1) || (MEM_LATENCY > MAX_MEM_LATENCY)) begin : g_bad_latency
    $fatal(1, "vec_tile_streamer: MEM_LATENCY must be 1..4");
  end

  state_t                r_state;
  state_t                w_next;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [LEN_WIDTH-1:0]  r_len;
  logic [EW-1:0]         r_base;   // element index of tile element 0
  logic [CNT_W-1:0]      r_issue;  // next beat slot to issue
  logic [CNT_W-1:0]      r_cap;    // beats written (captured or zeroed)
  logic                  r_err;
  logic [7:0]            r_tile [BEATS][MEM_BYTES];

  logic                  w_issuing;
  logic [BIDX_W-1:0]     w_issue_idx;
  logic [XW-1:0]         w_beat_first;
  logic                  w_beat_live;
  logic                  w_beat_zero;
  logic [MEM_BYTES-1:0]  w_mask;
  logic [XW-1:0]         w_tile_end;
  logic                  w_more;
  logic                  w_misalign;
  logic                  w_pipe_valid;
  logic [BIDX_W-1:0]     w_pipe_idx;
  logic [MEM_BYTES-1:0]  w_pipe_mask;
  logic                  w_cap_en;
  logic [CNT_W-1:0]      w_cap_total;
  logic                  w_hs;

  assign w_issuing    = (r_state == FETCH) && (r_issue < CNT_W'(BEATS));
  assign w_issue_idx  = r_issue[BIDX_W-1:0];
  assign w_beat_first = XW'(r_base) + XW'(r_issue) * XW'(MEM_BYTES);
  // Beats entirely past the end are never requested; their slot is zeroed.
  assign w_beat_live  = w_issuing && (w_beat_first < XW'(r_len));
  assign w_beat_zero  = w_issuing && !w_beat_live;
  assign w_tile_end   = XW'(r_base) + XW'(ELEM_COUNT);
  assign w_more       = w_tile_end < XW'(r_len);
  assign w_misalign   = (dram_addr & ADDR_WIDTH'(MEM_BYTES - 1)) != '0;
  assign w_cap_en     = (r_state == FETCH) && w_pipe_valid;
  assign w_cap_total  = r_cap + CNT_W'(w_beat_zero) + CNT_W'(w_cap_en);
  assign w_hs         = (r_state == HOLD) && tile_ready;

  for (genvar gk = 0; gk < MEM_BYTES; gk++) begin : g_mask
    assign w_mask[gk] = (w_beat_first + XW'(gk)) < XW'(r_len);
  end

  load_beat_pipe #(
    .LATENCY(MEM_LATENCY),
    .IDX_W  (BIDX_W),
    .MASK_W (MEM_BYTES)
  ) u_beat_pipe (
    .clk    (clk),
    .rst    (rst),
    .i_valid(w_beat_live),
    .i_idx  (w_issue_idx),
    .i_mask (w_mask),
    .o_valid(w_pipe_valid),
    .o_idx  (w_pipe_idx),
    .o_mask (w_pipe_mask)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (valid_in) begin
          if (w_misalign || (length == '0)) w_next = DONE;
          else                              w_next = FETCH;
        end
      end
      FETCH: if (w_cap_total == CNT_W'(BEATS)) w_next = HOLD;
      HOLD:  if (tile_ready) w_next = w_more ? FETCH : DONE;
      DONE:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    mem_req    = 1'b0;
    tile_valid = 1'b0;
    tile_last  = 1'b0;
    done       = 1'b0;
    err        = 1'b0;
    busy       = (r_state != IDLE);
    case (r_state)
      FETCH: mem_req = w_beat_live;
      HOLD: begin
        tile_valid = 1'b1;
        tile_last  = !w_more;
      end
      DONE: begin
        done = 1'b1;
        err  = r_err;
      end
      default: ;
    endcase
  end

  assign mem_addr = r_addr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr  <= '0;
      r_len   <= '0;
      r_base  <= '0;
      r_issue <= '0;
      r_cap   <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (valid_in) begin
            r_addr  <= dram_addr;
            r_len   <= length;
            r_base  <= '0;
            r_issue <= '0;
            r_cap   <= '0;
            r_err   <= w_misalign;
          end
        end
        FETCH: begin
          r_cap <= w_cap_total;
          if (w_issuing) begin
            r_issue <= r_issue + CNT_W'(1);
            r_addr  <= r_addr + ADDR_WIDTH'(MEM_BYTES);
          end
        end
        HOLD: begin
          if (w_hs && w_more) begin
            r_base  <= r_base + EW'(ELEM_COUNT);
            r_issue <= '0;
            r_cap   <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  // A returning beat and a zeroed beat never target the same slot in one cycle.
  for (genvar gb = 0; gb < BEATS; gb++) begin : g_beat
    for (genvar gk = 0; gk < MEM_BYTES; gk++) begin : g_lane
      always_ff @(posedge clk) begin
        if (rst) begin
          r_tile[gb][gk] <= '0;
        end else if (w_cap_en && (w_pipe_idx == BIDX_W'(gb))) begin
          r_tile[gb][gk] <= w_pipe_mask[gk] ? mem_rdata[8*gk +: 8] : 8'h00;
        end else if (w_beat_zero && (w_issue_idx == BIDX_W'(gb))) begin
          r_tile[gb][gk] <= '0;
        end
      end
      assign data_out[gb*MEM_BYTES + gk] = r_tile[gb][gk];
    end
  end

endmodule

// File: tb/tb_vec_tile_streamer.sv
// Directed bench for vec_tile_streamer: 32-element tiles, 4-byte beats,
// read latency 2. Memory returns byte k of a beat as (addr+k)[7:0].
module tb_vec_tile_streamer;

  localparam int unsigned EC = 32;
  localparam int unsigned AW = 24;
  localparam int unsigned LW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          valid_in;
  logic [AW-1:0] dram_addr;
  logic [LW-1:0] length;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_rdata;
  logic [7:0]    data_out [0:EC-1];
  logic          tile_valid;
  logic          tile_ready;
  logic          tile_last;
  logic          busy;
  logic          done;
  logic          err;

  int unsigned cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  vec_tile_streamer #(
    .TILE_WIDTH (256),
    .DATA_WIDTH (8),
    .MEM_BYTES  (4),
    .MEM_LATENCY(2),
    .ADDR_WIDTH (AW),
    .LEN_WIDTH  (LW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .valid_in  (valid_in),
    .dram_addr (dram_addr),
    .length    (length),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .data_out  (data_out),
    .tile_valid(tile_valid),
    .tile_ready(tile_ready),
    .tile_last (tile_last),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  // Two-cycle memory; not reset, so data for requests in flight at reset still returns.
  logic          m_v0 = 1'b0, m_v1 = 1'b0;
  logic [AW-1:0] m_a0 = '0, m_a1 = '0;
  logic [7:0]    m_lo;
  always @(posedge clk) begin
    m_v0 <= mem_req;
    m_a0 <= mem_addr;
    m_v1 <= m_v0;
    m_a1 <= m_a0;
  end
  always_comb begin
    m_lo = m_a1[7:0];
    if (m_v1) mem_rdata = {m_lo + 8'd3, m_lo + 8'd2, m_lo + 8'd1, m_lo};
    else      mem_rdata = 32'hA5A5_A5A5;
  end

  logic [AW-1:0]    req_q[$];
  int unsigned      reqcyc_q[$];
  logic [255:0]     tiles_q[$];
  logic             last_q[$];
  int unsigned      hs_q[$];
  bit               done_seen;
  int unsigned      done_cyc;
  logic             err_at_done;
  int unsigned      t_acc;

  function automatic logic [255:0] pack_out();
    logic [255:0] v;
    v = '0;
    for (int i = 0; i < EC; i++) v[8*i +: 8] = data_out[i];
    return v;
  endfunction

  function automatic logic [255:0] ramp(input logic [7:0] first, input int nvalid);
    logic [255:0] v;
    v = '0;
    for (int i = 0; i < nvalid; i++) v[8*i +: 8] = first + 8'(i);
    return v;
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (mem_req) begin
        req_q.push_back(mem_addr);
        reqcyc_q.push_back(cyc);
      end
      if (tile_valid && tile_ready) begin
        tiles_q.push_back(pack_out());
        last_q.push_back(tile_last);
        hs_q.push_back(cyc);
      end
      if (done) begin
        done_seen   = 1'b1;
        done_cyc    = cyc;
        err_at_done = err;
      end
    end
  end

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    req_q.delete();
    reqcyc_q.delete();
    tiles_q.delete();
    last_q.delete();
    hs_q.delete();
    done_seen   = 1'b0;
    done_cyc    = 0;
    err_at_done = 1'b0;
  endtask

  task automatic start(input logic [AW-1:0] a, input logic [LW-1:0] l);
    tick();
    dram_addr = a;
    length    = l;
    valid_in  = 1'b1;
    t_acc     = cyc;
    tick();
    valid_in  = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (!done_seen && n < budget) begin
      tick();
      n++;
    end
    check_eq("done_within_budget", done_seen, 1);
  endtask

  task automatic wait_tile_valid(input int budget);
    int n = 0;
    while (!tile_valid && n < budget) begin
      tick();
      n++;
    end
    check_eq("tile_valid_within_budget", tile_valid, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [255:0] snap;
    rst = 1'b1; valid_in = 1'b0; dram_addr = '0; length = '0; tile_ready = 1'b0;
    clear_log();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    check_eq("rst_ctrl", {mem_req, tile_valid, tile_last, busy, done, err}, 6'b0);
    check_eq("rst_addr", mem_addr, 0);
    check_eq("rst_data", pack_out(), 0);

    // One full tile, consumer always ready.
    tile_ready = 1'b1;
    clear_log();
    start(24'h000100, 16'd32);
    wait_done(60);
    check_eq("t32_nreq", req_q.size(), 8);
    for (int b = 0; b < 8; b++) begin
      check_eq("t32_addr", req_q[b], 24'h000100 + 4 * b);
      check_eq("t32_req_cyc", reqcyc_q[b], t_acc + 1 + b);
    end
    check_eq("t32_ntiles", tiles_q.size(), 1);
    check_eq("t32_tile", tiles_q[0], ramp(8'h00, 32));
    check_eq("t32_last", last_q[0], 1);
    check_eq("t32_hs_cyc", hs_q[0], t_acc + 11);
    check_eq("t32_done_cyc", done_cyc, hs_q[0] + 1);
    check_eq("t32_err", err_at_done, 0);

    // Two tiles, second one 8 elements.
    clear_log();
    start(24'h000000, 16'd40);
    wait_done(80);
    check_eq("t40_nreq", req_q.size(), 10);
    check_eq("t40_addr8", req_q[8], 24'h20);
    check_eq("t40_addr9", req_q[9], 24'h24);
    check_eq("t40_next_req_cyc", reqcyc_q[8], hs_q[0] + 1);
    check_eq("t40_ntiles", tiles_q.size(), 2);
    check_eq("t40_tile0", tiles_q[0], ramp(8'h00, 32));
    check_eq("t40_last0", last_q[0], 0);
    check_eq("t40_tile1", tiles_q[1], ramp(8'h20, 8));
    check_eq("t40_last1", last_q[1], 1);

    // Partial beat inside the last tile.
    clear_log();
    start(24'h000000, 16'd35);
    wait_done(80);
    check_eq("t35_nreq", req_q.size(), 9);
    check_eq("t35_addr8", req_q[8], 24'h20);
    check_eq("t35_tile1", tiles_q[1], ramp(8'h20, 3));
    check_eq("t35_last1", last_q[1], 1);

    // Backpressure on the first of two tiles.
    tile_ready = 1'b0;
    clear_log();
    start(24'h000200, 16'd64);
    wait_tile_valid(40);
    snap = pack_out();
    check_eq("bp_snap", snap, ramp(8'h00, 32));
    check_eq("bp_last0", tile_last, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("bp_hold", {tile_valid, mem_req, (pack_out() == snap)}, 3'b101);
    end
    tile_ready = 1'b1;
    tick();
    tile_ready = 1'b0;
    check_eq("bp_next_req", {tile_valid, mem_req}, 2'b01);
    check_eq("bp_next_addr", mem_addr, 24'h000220);
    tile_ready = 1'b1;
    wait_done(60);
    check_eq("bp_ntiles", tiles_q.size(), 2);
    check_eq("bp_tile1", tiles_q[1], ramp(8'h20, 32));
    check_eq("bp_last1", last_q[1], 1);

    // Zero length.
    clear_log();
    start(24'h000100, 16'd0);
    check_eq("len0_busy", busy, 1);
    wait_done(10);
    check_eq("len0_done_cyc", done_cyc, t_acc + 1);
    check_eq("len0_nreq", req_q.size(), 0);
    check_eq("len0_ntiles", tiles_q.size(), 0);
    check_eq("len0_err", err_at_done, 0);

    // Misaligned start address.
    clear_log();
    start(24'h000102, 16'd32);
    wait_done(10);
    check_eq("mis_done_cyc", done_cyc, t_acc + 1);
    check_eq("mis_err", err_at_done, 1);
    check_eq("mis_nreq", req_q.size(), 0);
    check_eq("mis_ntiles", tiles_q.size(), 0);

    // A second start while busy is dropped.
    clear_log();
    start(24'h000100, 16'd32);
    tick();
    dram_addr = 24'h000300;
    length    = 16'd4;
    valid_in  = 1'b1;
    tick();
    valid_in  = 1'b0;
    wait_done(60);
    repeat (4) tick();
    check_eq("busyin_nreq", req_q.size(), 8);
    check_eq("busyin_addr0", req_q[0], 24'h000100);
    check_eq("busyin_ntiles", tiles_q.size(), 1);
    check_eq("busyin_tile", tiles_q[0], ramp(8'h00, 32));
    check_eq("busyin_idle", busy, 0);

    // Reset with two beats in flight, then a clean transfer.
    clear_log();
    start(24'h000100, 16'd32);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("midrst_ctrl", {mem_req, tile_valid, tile_last, busy, done, err}, 6'b0);
    check_eq("midrst_addr", mem_addr, 0);
    check_eq("midrst_data", pack_out(), 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("midrst_late_data", {tile_valid, busy, pack_out()}, 0);
    end
    clear_log();
    start(24'h000040, 16'd32);
    wait_done(60);
    check_eq("postrst_nreq", req_q.size(), 8);
    check_eq("postrst_ntiles", tiles_q.size(), 1);
    check_eq("postrst_tile", tiles_q[0], ramp(8'h40, 32));
    check_eq("postrst_last", last_q[0], 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
